// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALU/mux selects and FSM states.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_RWB    = 4'd7,
    S_IEX    = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  // State that follows DECODE; unsupported opcodes fall back to FETCH as a NOP.
  function automatic state_t decode_target(input logic [5:0] op);
    case (op)
      OP_RTYPE:                         decode_target = S_REX;
      OP_LW, OP_SW:                     decode_target = S_MEMADR;
      OP_BEQ, OP_BNE:                   decode_target = S_BRANCH;
      OP_J:                             decode_target = S_JUMP;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: decode_target = S_IEX;
      default:                          decode_target = S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational map from controller state (plus handshake/qualifier inputs) to the datapath control vector.
module mc_output_decode
  import mips_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic [5:0] op_q,
  input  logic       zero,
  input  logic       mem_ready,
  input  logic       stall,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       instr_done,
  output logic       illegal_op
);

  always_comb begin
    pc_we      = 1'b0;
    pc_src     = PC_ALU;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALU_ADD;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state_t'(state))
      S_FETCH: begin
        alu_src_b = SRCB_FOUR;
        mem_read  = !stall;
        ir_write  = !stall && mem_ready;
        pc_we     = !stall && mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_IMM_SH2;
        illegal_op = (decode_target(opcode) == S_FETCH);
        instr_done = illegal_op;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
      end
      S_REX: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_IEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        case (op_q)
          OP_ANDI: alu_op = ALU_AND;
          OP_ORI:  alu_op = ALU_OR;
          OP_SLTI: alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      S_IWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = PC_ALUOUT;
        pc_we      = (op_q == OP_BNE) ? !zero : zero;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_src     = PC_JUMP;
        pc_we      = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS controller: state register, memory wait/timeout counter and output qualification.
module multicycle_controller
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  input  logic       stall,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       bus_err,
  output logic [3:0] state_o
);

  state_t           state, state_nx;
  logic [CNT_W-1:0] wait_cnt;
  logic [5:0]       op_q;
  logic             waiting, timeout, wr_block;
  logic             pc_we_d, mem_read_d, mem_write_d, ir_write_d, reg_write_d;
  logic             instr_done_d, illegal_op_d;

  assign waiting = ((state == S_FETCH) && !stall) || (state == S_MEMRD) || (state == S_MEMWR);
  assign timeout = waiting && !mem_ready && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_nx;
      // An aborted access re-enters its target state, so it restarts the count too.
      if ((state_nx != state) || timeout)
        wait_cnt <= '0;
      else if (waiting && !mem_ready)
        wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_DECODE)
      op_q <= opcode;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  if (!stall && mem_ready) state_nx = S_DECODE;
      S_DECODE: state_nx = decode_target(opcode);
      S_MEMADR: state_nx = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_nx = S_MEMWB;
                else if (timeout) state_nx = S_FETCH;
      S_MEMWR:  if (mem_ready || timeout) state_nx = S_FETCH;
      S_REX:    state_nx = S_RWB;
      S_IEX:    state_nx = S_IWB;
      default:  state_nx = S_FETCH;
    endcase
  end

  mc_output_decode u_decode (
    .state      (state),
    .opcode     (opcode),
    .op_q       (op_q),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .stall      (stall),
    .pc_we      (pc_we_d),
    .pc_src     (pc_src),
    .iord       (iord),
    .mem_read   (mem_read_d),
    .mem_write  (mem_write_d),
    .ir_write   (ir_write_d),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write_d),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .instr_done (instr_done_d),
    .illegal_op (illegal_op_d)
  );

  // Reset and a timed-out access both suppress every architectural write in the current cycle.
  assign wr_block   = !rst_n || timeout;
  assign pc_we      = pc_we_d && !wr_block;
  assign ir_write   = ir_write_d && !wr_block;
  assign reg_write  = reg_write_d && !wr_block;
  assign mem_write  = mem_write_d && !wr_block;
  assign mem_read   = mem_read_d && rst_n;
  assign instr_done = instr_done_d && !wr_block;
  assign illegal_op = illegal_op_d && rst_n;
  assign bus_err    = timeout && rst_n;
  assign state_o    = state;

endmodule
